led_sweep_ctrl: RTL

Sequencer that drives the 4-bit index input of the 10-LED one-hot decoder, stepping the lit LED across positions 0..9 at a programmable rate. Supports ping-pong (bounce), wrap-up, wrap-down and hold patterns with start/pause/resume/clear control. Sits between board switches/buttons (already synchronised and debounced to single-cycle pulses) and the decoder; its `pos` output connects directly to the decoder's `x`.

---
 rtl/led_sweep_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/led_sweep_ctrl.sv
// Sweep sequencer for the 10-LED one-hot decoder: steps a position 0..9 at a
// programmable rate in bounce, wrap-up, wrap-down or hold patterns.
module led_sweep_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
    output logic [3:0] pos,
    output logic       dir,
    output logic       running,
    output logic       endpt
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_UP     = 2'd1;
    localparam logic [1:0] MODE_DOWN   = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    localparam logic [3:0] POS_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    mult_q, mult_d;
    logic [3:0]    pos_q, pos_d;
    logic          dir_q, dir_d;
    logic          endpt_q, endpt_d;

    // Returns {dir, pos} after one step; out-of-range positions fold back
    // into 0..9 so a corrupted register can never escape the legal range.
    function automatic logic [4:0] step_next(input logic [1:0] m,
                                             input logic [3:0] p,
                                             input logic       d);
        logic [4:0] r;
        r = {d, p};
        case (m)
            MODE_BOUNCE: begin
                if (d) begin
                    r = (p >= POS_MAX) ? {1'b0, 4'd8} : {1'b1, p + 4'd1};
                end else begin
                    if (p == 4'd0)
                        r = {1'b1, 4'd1};
                    else if (p > POS_MAX)
                        r = {1'b0, 4'd8};
                    else
                        r = {1'b0, p - 4'd1};
                end
            end
            MODE_UP: begin
                r = (p >= POS_MAX) ? {1'b1, 4'd0} : {1'b1, p + 4'd1};
            end
            MODE_DOWN: begin
                r = (p == 4'd0 || p > POS_MAX) ? {1'b0, POS_MAX} : {1'b0, p - 4'd1};
            end
            default: r = {d, p};
        endcase
        return r;
    endfunction

    function automatic logic is_endpoint(input logic [3:0] p);
        return (p == 4'd0) || (p == POS_MAX);
    endfunction

    logic       presc_wrap;
    logic [4:0] stepped;

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        mult_d     = mult_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        endpt_d    = 1'b0;
        presc_wrap = (presc_q == PRESC_MAX);
        stepped    = step_next(mode, pos_q, dir_q);

        if (clear) begin
            state_d = S_IDLE;
            presc_d = '0;
            mult_d  = '0;
            pos_d   = 4'd0;
            dir_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                        presc_d = '0;
                        mult_d  = '0;
                        if (mode == MODE_DOWN) begin
                            pos_d = POS_MAX;
                            dir_d = 1'b0;
                        end else begin
                            pos_d = 4'd0;
                            dir_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                        presc_d = '0;
                        mult_d  = '0;
                    end else if (presc_wrap) begin
                        presc_d = '0;
                        if (mult_q == speed) begin
                            mult_d  = '0;
                            dir_d   = stepped[4];
                            pos_d   = stepped[3:0];
                            endpt_d = (mode != MODE_HOLD) && is_endpoint(stepped[3:0]);
                        end else if (mult_q > speed) begin
                            // speed was lowered mid-period: restart the period, no step
                            mult_d = '0;
                        end else begin
                            mult_d = mult_q + 2'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                        presc_d = '0;
                        mult_d  = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    mult_d  = '0;
                    pos_d   = 4'd0;
                    dir_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            mult_q  <= '0;
            pos_q   <= 4'd0;
            dir_q   <= 1'b1;
            endpt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            mult_q  <= mult_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            endpt_q <= endpt_d;
        end
    end

    assign pos     = pos_q;
    assign dir     = dir_q;
    assign running = (state_q == S_RUN);
    assign endpt   = endpt_q;

endmodule
